// File: rtl/ssp_opamp_pkg.sv
// Shared types and constants for the SSP opamp offset-trim calibrator.
package ssp_opamp_pkg;

    localparam int NCH_MIN    = 1;
    localparam int NCH_MAX    = 4;
    localparam int TW_MIN     = 3;
    localparam int TW_MAX     = 8;
    localparam int SETTLE_MIN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SETTLE,
        ST_DECIDE,
        ST_NEXT,
        ST_DONE
    } state_t;

    function automatic int midscale(input int tw);
        return 1 << (tw - 1);
    endfunction

endpackage

// File: rtl/ssp_sync2.sv
// Two-flop synchroniser for the asynchronous comparator outputs.
module ssp_sync2 #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ssp_opamp_trim_cal.sv
// Per-channel SAR offset-trim calibrator: walks the masked channels in order,
// searches each trim code against its comparator, then holds the result.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for start; manual trim writes accepted
// ST_SETUP  | back up channel trim, load mid-scale trial, close auto-zero
// ST_SETTLE | trial code applied, settle counter running down
// ST_DECIDE | keep/clear current bit from comparator, set next bit
// ST_NEXT   | flag saturation, open auto-zero, pick next masked channel
// ST_DONE   | one-cycle done pulse
module ssp_opamp_trim_cal
    import ssp_opamp_pkg::*;
#(
    parameter int NCH    = 2,
    parameter int TW     = 6,
    parameter int SETTLE = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [NCH-1:0]    ch_mask,
    input  logic [NCH-1:0]    cmp_in,
    input  logic              trim_wr,
    input  logic [1:0]        trim_ch,
    input  logic [TW-1:0]     trim_wdata,
    output logic [NCH*TW-1:0] trim_out,
    output logic [NCH-1:0]    az_en,
    output logic              busy,
    output logic              done,
    output logic [NCH-1:0]    cal_err
);

    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int BW  = $clog2(TW);
    localparam int CW  = $clog2(SETTLE + 1);
    localparam logic [TW-1:0] MID = TW'(midscale(TW));

    state_t          state;
    logic [TW-1:0]   trim_q [NCH];
    logic [TW-1:0]   backup;
    logic [TW-1:0]   decide_code;
    logic [BW-1:0]   bit_idx;
    logic [CW-1:0]   cnt;
    logic [CHW-1:0]  ch;
    logic [NCH-1:0]  mask_q;
    logic [NCH-1:0]  cmp_sync;
    logic [CHW:0]    first_sel;
    logic [CHW:0]    next_sel;

    // Returns {found, index} of the lowest set mask bit at or above 'from'.
    function automatic logic [CHW:0] find_ch(input logic [NCH-1:0] m, input int from);
        logic [CHW:0] r;
        r = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (i >= from && m[i]) r = {1'b1, CHW'(i)};
        end
        return r;
    endfunction

    ssp_sync2 #(.W(NCH)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (cmp_in),
        .q   (cmp_sync)
    );

    assign first_sel = find_ch(ch_mask, 0);
    assign next_sel  = find_ch(mask_q, int'(ch) + 1);

    always_comb begin
        decide_code          = trim_q[ch];
        decide_code[bit_idx] = cmp_sync[ch];
        if (bit_idx != '0) decide_code[bit_idx - 1'b1] = 1'b1;
    end

    for (genvar c = 0; c < NCH; c++) begin : g_out
        assign trim_out[c*TW +: TW] = trim_q[c];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            for (int c = 0; c < NCH; c++) trim_q[c] <= MID;
            backup  <= MID;
            bit_idx <= '0;
            cnt     <= '0;
            ch      <= '0;
            mask_q  <= '0;
            az_en   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            cal_err <= '0;
        end else begin
            done <= 1'b0;
            if (abort && state != ST_IDLE) begin
                // SETUP has not touched the trim yet, and DONE has no active channel.
                if (state inside {ST_SETTLE, ST_DECIDE, ST_NEXT}) trim_q[ch] <= backup;
                az_en <= '0;
                busy  <= 1'b0;
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (trim_wr && int'(trim_ch) < NCH) trim_q[trim_ch[CHW-1:0]] <= trim_wdata;
                        if (start) begin
                            cal_err <= '0;
                            mask_q  <= ch_mask;
                            busy    <= 1'b1;
                            if (first_sel[CHW]) begin
                                ch    <= first_sel[CHW-1:0];
                                state <= ST_SETUP;
                            end else begin
                                done  <= 1'b1;
                                state <= ST_DONE;
                            end
                        end
                    end
                    ST_SETUP: begin
                        backup     <= trim_q[ch];
                        trim_q[ch] <= MID;
                        az_en      <= NCH'(1) << ch;
                        bit_idx    <= BW'(TW - 1);
                        cnt        <= CW'(SETTLE);
                        state      <= ST_SETTLE;
                    end
                    ST_SETTLE: begin
                        cnt <= cnt - 1'b1;
                        if (cnt == CW'(1)) state <= ST_DECIDE;
                    end
                    ST_DECIDE: begin
                        trim_q[ch] <= decide_code;
                        if (bit_idx != '0) begin
                            bit_idx <= bit_idx - 1'b1;
                            cnt     <= CW'(SETTLE);
                            state   <= ST_SETTLE;
                        end else begin
                            state <= ST_NEXT;
                        end
                    end
                    ST_NEXT: begin
                        if (trim_q[ch] == '0 || trim_q[ch] == '1) cal_err[ch] <= 1'b1;
                        az_en <= '0;
                        if (next_sel[CHW]) begin
                            ch    <= next_sel[CHW-1:0];
                            state <= ST_SETUP;
                        end else begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ssp_opamp_trim_cal.sv
// Bench for ssp_opamp_trim_cal: timeline model of each run checked every cycle.
module tb_ssp_opamp_trim_cal;

    localparam int NCH  = 2;
    localparam int TW   = 4;
    localparam int S    = 3;
    localparam int PER  = TW * (S + 1) + 2;
    localparam int FULL = (1 << TW) - 1;
    localparam int MID  = 1 << (TW - 1);

    logic              clk = 1'b0;
    logic              rst, start, abort, trim_wr;
    logic [NCH-1:0]    ch_mask, cmp_in;
    logic [1:0]        trim_ch;
    logic [TW-1:0]     trim_wdata;
    logic [NCH*TW-1:0] trim_out;
    logic [NCH-1:0]    az_en, cal_err;
    logic              busy, done;

    logic [11:0] trim6;
    logic [1:0]  az6, err6;
    logic        busy6, done6;

    always #5 clk = ~clk;

    ssp_opamp_trim_cal #(.NCH(NCH), .TW(TW), .SETTLE(S)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .ch_mask(ch_mask),
        .cmp_in(cmp_in), .trim_wr(trim_wr), .trim_ch(trim_ch), .trim_wdata(trim_wdata),
        .trim_out(trim_out), .az_en(az_en), .busy(busy), .done(done), .cal_err(cal_err)
    );

    ssp_opamp_trim_cal dut6 (
        .clk(clk), .rst(rst), .start(1'b0), .abort(1'b0), .ch_mask(2'b00),
        .cmp_in(2'b00), .trim_wr(1'b0), .trim_ch(2'b00), .trim_wdata(6'd0),
        .trim_out(trim6), .az_en(az6), .busy(busy6), .done(done6), .cal_err(err6)
    );

    // Analog stand-in: 0 = comparator says trial <= target, 1 = stuck high, 2 = stuck low.
    int mode;
    int target [NCH];
    always_comb begin
        cmp_in = '0;
        for (int c = 0; c < NCH; c++)
            cmp_in[c] = (mode == 0) ? (int'(trim_out[c*TW +: TW]) <= target[c]) : (mode == 1);
    end

    int total = 0, bad = 0;
    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int             exp_trim [NCH];
    logic [NCH-1:0] exp_err;
    int             pre [NCH], res [NCH], lit_tr [NCH];
    int             order [$];
    int             abort_cyc, pin, lit_done, t0;
    bit             run_on = 0, chk_on = 0;

    task automatic chk(input string nm, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at t=%0t", nm, act, expv, $time);
        end
    endtask

    function automatic int tr(input int c);
        return int'(trim_out[c*TW +: TW]);
    endfunction

    int             n, tt, ci, lo, hi, got_done;
    bit             ab;
    int             e_tr [NCH];
    bit             e_skip [NCH];
    logic [NCH-1:0] e_az, e_err;

    always @(negedge clk) begin
        if (chk_on) begin
            for (int c = 0; c < 2; c++) chk("ref6_trim", int'(trim6[c*6 +: 6]), 32);
            chk("ref6_ctl", int'({busy6, done6, az6, err6}), 0);
            if (!run_on) begin
                for (int c = 0; c < NCH; c++) chk("idle_trim", tr(c), exp_trim[c]);
                chk("idle_busy", int'(busy), 0);
                chk("idle_done", int'(done), 0);
                chk("idle_az", int'(az_en), 0);
                chk("idle_err", int'(cal_err), int'(exp_err));
            end else begin
                n = edge_cnt - t0 + 1;
                if (n == 1) got_done = -1;
                if (done) got_done = n;
                tt = order.size() * PER + 1;
                ab = (abort_cyc >= 0) && (n > abort_cyc);
                e_az = '0;
                e_err = '0;
                for (int c = 0; c < NCH; c++) begin
                    e_tr[c] = pre[c];
                    e_skip[c] = 0;
                end
                for (int j = 0; j < order.size(); j++) begin
                    ci = order[j];
                    lo = 2 + j * PER;
                    hi = (j + 1) * PER;
                    if (!ab && n >= lo && n <= hi) e_az = NCH'(1) << ci;
                    if ((abort_cyc < 0 || abort_cyc > hi) && n > hi) begin
                        e_tr[ci] = res[ci];
                        if (res[ci] == 0 || res[ci] == FULL) e_err[ci] = 1'b1;
                    end else if (!ab && n >= lo && n <= hi) begin
                        e_skip[ci] = 1;
                    end
                end
                chk("run_busy", int'(busy), int'(!ab && n <= tt));
                chk("run_done", int'(done), int'(!ab && n == tt));
                chk("run_az", int'(az_en), int'(e_az));
                chk("run_err", int'(cal_err), int'(e_err));
                for (int c = 0; c < NCH; c++)
                    if (!e_skip[c]) chk("run_trim", tr(c), e_tr[c]);
                if (n == pin) begin
                    chk("pin_done_cycle", got_done, lit_done);
                    for (int c = 0; c < NCH; c++)
                        if (lit_tr[c] >= 0) chk("pin_trim", tr(c), lit_tr[c]);
                end
            end
        end
    end

    task automatic wr(input int ch, input int val);
        trim_wr = 1'b1;
        trim_ch = 2'(ch);
        trim_wdata = TW'(val);
        @(posedge clk); #1;
        trim_wr = 1'b0;
        if (ch < NCH) exp_trim[ch] = val;
    endtask

    // One calibration run; ab_c/bw_c/rst_c name the cycle an abort, a busy
    // write+start, or a reset is held (-1 = none). wr_ch writes alongside start.
    task automatic run(input logic [1:0] mask, input int m, input int tg0, input int tg1,
                       input int ab_c, input int bw_c, input int rst_c,
                       input int wr_ch, input int wr_val,
                       input int ld, input int l0, input int l1);
        int last;
        mode = m;
        target[0] = tg0;
        target[1] = tg1;
        ch_mask = mask;
        for (int c = 0; c < NCH; c++) pre[c] = exp_trim[c];
        if (wr_ch >= 0) begin
            trim_wr = 1'b1;
            trim_ch = 2'(wr_ch);
            trim_wdata = TW'(wr_val);
            if (wr_ch < NCH) pre[wr_ch] = wr_val;
        end
        order.delete();
        for (int c = 0; c < NCH; c++) if (mask[c]) order.push_back(c);
        for (int c = 0; c < NCH; c++) res[c] = (m == 1) ? FULL : (m == 2) ? 0 : target[c];
        abort_cyc = ab_c;
        lit_done = ld;
        lit_tr[0] = l0;
        lit_tr[1] = l1;
        pin = (rst_c >= 0) ? -1 : (ab_c >= 0) ? ab_c + 2 : order.size() * PER + 2;
        last = (rst_c >= 0) ? rst_c : pin;
        start = 1'b1;
        @(posedge clk); #1;
        t0 = edge_cnt;
        run_on = 1;
        start = 1'b0;
        trim_wr = 1'b0;
        for (int e = 1; e <= last; e++) begin
            abort = (e == ab_c);
            start = (e == bw_c);
            trim_wr = (e == bw_c);
            if (e == bw_c) begin
                trim_ch = 2'd0;
                trim_wdata = TW'(7);
            end
            rst = (e == rst_c);
            @(posedge clk); #1;
        end
        abort = 1'b0;
        start = 1'b0;
        trim_wr = 1'b0;
        rst = 1'b0;
        run_on = 0;
        if (rst_c >= 0) begin
            for (int c = 0; c < NCH; c++) exp_trim[c] = MID;
            exp_err = '0;
        end else begin
            exp_err = '0;
            for (int c = 0; c < NCH; c++) exp_trim[c] = pre[c];
            for (int j = 0; j < order.size(); j++) begin
                if (ab_c < 0 || ab_c > (j + 1) * PER) begin
                    exp_trim[order[j]] = res[order[j]];
                    if (res[order[j]] == 0 || res[order[j]] == FULL) exp_err[order[j]] = 1'b1;
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        trim_wr = 1'b0;
        trim_ch = '0;
        trim_wdata = '0;
        ch_mask = '0;
        mode = 0;
        target[0] = 0;
        target[1] = 0;
        for (int c = 0; c < NCH; c++) exp_trim[c] = MID;
        exp_err = '0;
        abort_cyc = -1;
        pin = -1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_on = 1;
        @(posedge clk); #1;

        run(2'b11, 0, 9, 3, -1, -1, -1, -1, 0, 37, 9, 3);
        run(2'b11, 1, 0, 0, -1, -1, -1, -1, 0, 37, 15, 15);
        run(2'b11, 2, 0, 0, -1, -1, -1, -1, 0, 37, 0, 0);
        wr(0, 5);
        wr(3, 11);
        run(2'b10, 0, 0, 12, -1, -1, -1, 1, 2, 19, 5, 12);
        run(2'b11, 0, 6, 10, 31, -1, -1, -1, 0, -1, 6, 12);
        run(2'b11, 0, 1, 14, -1, 10, -1, -1, 0, 37, 1, 14);
        run(2'b11, 0, 9, 3, -1, -1, 25, -1, 0, -1, -1, -1);
        run(2'b00, 0, 0, 0, -1, -1, -1, -1, 0, 1, 8, 8);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ssp_opamp_trim_cal.md
# ssp_opamp_trim_cal

Parametrised digital offset-trim calibrator for the SSP opamp tile, generalising the single fixed opamp to NCH channels with TW-bit trim DACs. For each enabled channel it closes an auto-zero loop with a successive-approximation (SAR) search on the channel comparator output, then holds the resulting trim code. It sits between the tile's digital pins (ui_in/uio) and the analog opamp array, and drives trim DAC bits and auto-zero switches.

## Interface
- NCH, 2: opamp channel count (1..4)
- TW, 6: trim code width per channel (3..8)
- SETTLE, 15: settle cycles after each trial-code update; must be ≥2
- clk  in  1  sole clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin calibration; sampled only in IDLE
- abort  in  1  cancel an in-progress calibration
- ch_mask  in  NCH  1 = calibrate channel, 0 = skip
- cmp_in  in  NCH  asynchronous comparator outputs from the analog array
- trim_wr  in  1  manual trim write strobe; honoured only in IDLE
- trim_ch  in  2  manual write channel index; values ≥NCH ignored
- trim_wdata  in  TW  manual trim value
- trim_out  out  NCH*TW  trim codes, channel c at [c*TW +: TW]
- az_en  out  NCH  auto-zero switch enable, at most one bit high
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at end of a run
- cal_err  out  NCH  sticky: channel result saturated (all-0 or all-1)

## Operation
- Reset: trim_out = mid-scale (1 << (TW-1)) per channel; az_en, busy, done, cal_err = 0; state IDLE.
- FSM: IDLE → SETUP → SETTLE → DECIDE → (SETTLE | NEXT) → (SETUP | DONE) → IDLE.
- IDLE + start: clear cal_err, ch = lowest masked channel; go to SETUP. If ch_mask == 0, go directly to DONE.
- SETUP (1 cycle): save channel's current trim as backup; trial = MSB only; az_en[ch] = 1; bit = TW-1; counter = SETTLE.
- SETTLE (SETTLE cycles): trim_out[ch] drives trial; count down.
- DECIDE (1 cycle): sample synchronised cmp[ch]. 1 keeps the bit, 0 clears it. If bit > 0, set bit-1 in trial and return to SETTLE; otherwise go to NEXT.
- NEXT (1 cycle): commit trial; set cal_err[ch] if trial is all-0 or all-1; az_en = 0; advance to the next masked channel (SETUP), or go to DONE.
- DONE (1 cycle): done = 1, then IDLE.
- Unmasked channels keep their trim throughout. Non-active channels' trim_out is stable during a run.
- abort in any busy state: next cycle restore active channel's backup trim; az_en = 0; state IDLE; no done pulse. Already-committed channels keep their new codes.
- start while busy: ignored. trim_wr while busy: ignored. trim_wr in IDLE updates trim_out[trim_ch] next cycle.
- Simultaneous start and trim_wr in IDLE: the write applies, then calibration overwrites it if the channel is masked.

## Timing
- cmp_in passes through a 2-flop synchroniser, so DECIDE sees cmp_in from 2 cycles earlier. SETTLE ≥2 guarantees the sample reflects the current trial.
- Per channel: 1 + TW*(SETTLE+1) + 1 cycles.
- With start sampled at edge 0 and k masked channels, done is high in cycle k*(TW*(SETTLE+1)+2)+1.
- All outputs are registered.

## Structure
- Package ssp_opamp_pkg: state enum (IDLE, SETUP, SETTLE, DECIDE, NEXT, DONE), a midscale function of TW, and the NCH/TW range constants.
- Sub-module ssp_sync2: NCH-wide 2-flop synchroniser, reset to 0.
- Top: FSM, settle counter, per-channel trim register file, backup register, sticky error bits.

## Test plan
- Reset: after rst, trim_out = 0x20 for every channel (TW=6); busy = 0, az_en = 0, cal_err = 0.
- SAR convergence (NCH=2, TW=4, SETTLE=3, mask = 2'b11): model cmp = (trial ≤ target), targets 9 and 3. Result: trims 9 and 3, done in cycle 37, az_en one-hot per channel in turn.
- Saturation: cmp held at 1 → trim = all-ones and cal_err set; cmp held at 0 → trim = 0 and cal_err set. Both cleared by the next start.
- Mask skip: mask = 2'b10 with channel 0 preset to 5 via trim_wr. Channel 0 stays 5 and done arrives in cycle 19.
- Abort: abort during the 3rd DECIDE of channel 1 → channel 1 restored to its prior code, channel 0 keeps its new code, no done, IDLE next cycle.
- Busy rejection: trim_wr and start during a run are ignored. rst asserted mid-run returns all outputs to reset values on the next edge.
